// File: rtl/cursor_input_ctrl.sv
// Button front end for the battleship board: synchronises and debounces the
// five raw buttons, runs a press/hold/auto-repeat FSM per direction, keeps
// the targeting cursor on the grid and emits a clean fire strobe.
module cursor_input_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned REPEAT_DELAY    = 50000000,
    parameter int unsigned REPEAT_RATE     = 15000000,
    parameter int unsigned GRID_SIZE       = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_u,
    input  logic       btn_d,
    input  logic       btn_l,
    input  logic       btn_r,
    input  logic       btn_c,
    input  logic       game_over,
    output logic [3:0] sprite_row,
    output logic [3:0] sprite_col,
    output logic       fire,
    output logic       cursor_moved
);

    localparam int unsigned DW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

    localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);
    localparam logic [3:0]    LAST       = 4'(GRID_SIZE - 1);

    // Button index: 0 up, 1 down, 2 left, 3 right, 4 centre
    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        REPEAT
    } dir_state_t;

    logic [4:0]    raw;
    logic [4:0]    sync1;
    logic [4:0]    sync2;
    logic [4:0]    deb;
    logic [4:0]    deb_d;
    logic [4:0]    press;
    logic [DW-1:0] deb_cnt [5];

    dir_state_t    state      [4];
    dir_state_t    state_next [4];
    logic [RW-1:0] rcnt       [4];
    logic [RW-1:0] rcnt_next  [4];
    logic [3:0]    step;

    logic [3:0]    row_next;
    logic [3:0]    col_next;

    assign raw   = {btn_c, btn_r, btn_l, btn_d, btn_u};
    assign press = deb & ~deb_d;

    // Two-flop synchroniser followed by a per-button stability counter
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            deb_d <= '0;
            for (int unsigned i = 0; i < 5; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            deb_d <= deb;
            for (int unsigned i = 0; i < 5; i++) begin
                if (sync2[i] == deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    deb[i]     <= sync2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Direction FSM state and hold/repeat counters
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < 4; i++) begin
                state[i] <= IDLE;
                rcnt[i]  <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                state[i] <= state_next[i];
                rcnt[i]  <= rcnt_next[i];
            end
        end
    end

    // Step on press, again after the hold delay, then at the repeat rate;
    // a release seen in the same cycle as a due step wins over the step
    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            state_next[i] = state[i];
            rcnt_next[i]  = rcnt[i];
            step[i]       = 1'b0;
            case (state[i])
                IDLE: begin
                    if (press[i]) begin
                        step[i]       = 1'b1;
                        state_next[i] = HOLD;
                        rcnt_next[i]  = '0;
                    end
                end
                HOLD: begin
                    if (!deb[i]) begin
                        state_next[i] = IDLE;
                        rcnt_next[i]  = '0;
                    end else if (rcnt[i] == DELAY_LAST) begin
                        step[i]       = 1'b1;
                        state_next[i] = REPEAT;
                        rcnt_next[i]  = '0;
                    end else begin
                        rcnt_next[i] = rcnt[i] + 1'b1;
                    end
                end
                REPEAT: begin
                    if (!deb[i]) begin
                        state_next[i] = IDLE;
                        rcnt_next[i]  = '0;
                    end else if (rcnt[i] == RATE_LAST) begin
                        step[i]      = 1'b1;
                        rcnt_next[i] = '0;
                    end else begin
                        rcnt_next[i] = rcnt[i] + 1'b1;
                    end
                end
                default: begin
                    state_next[i] = IDLE;
                    rcnt_next[i]  = '0;
                end
            endcase
        end
    end

    // Next cursor position with wrap; opposing steps cancel per axis
    always_comb begin
        row_next = sprite_row;
        col_next = sprite_col;
        if (step[0] && !step[1]) begin
            row_next = (sprite_row == 4'd0) ? LAST : sprite_row - 4'd1;
        end else if (step[1] && !step[0]) begin
            row_next = (sprite_row == LAST) ? 4'd0 : sprite_row + 4'd1;
        end
        if (step[2] && !step[3]) begin
            col_next = (sprite_col == 4'd0) ? LAST : sprite_col - 4'd1;
        end else if (step[3] && !step[2]) begin
            col_next = (sprite_col == LAST) ? 4'd0 : sprite_col + 4'd1;
        end
    end

    // Registered cursor, movement strobe and fire strobe
    always_ff @(posedge clk) begin
        if (reset) begin
            sprite_row   <= '0;
            sprite_col   <= '0;
            cursor_moved <= 1'b0;
            fire         <= 1'b0;
        end else begin
            sprite_row   <= row_next;
            sprite_col   <= col_next;
            cursor_moved <= (row_next != sprite_row) || (col_next != sprite_col);
            fire         <= press[4] && !game_over;
        end
    end

endmodule
